row_subband_reorder: RTL and testbench
======================================

Name: row_subband_reorder

Overview:
- Sits directly downstream of the row DWT97 stage.
- Consumes its row-interleaved coefficient pairs {high, low}, one pair per beat, and re-emits each row in subband order: all L coefficients of the row, then all H coefficients, one coefficient per beat.
- Ping-pong line buffering lets row r+1 be written while row r is read out, so the column stage receives contiguous L/H half-rows.

Parameters:
- DataWidth, 16: width of one coefficient (two's complement).
- MaximumSideSize, 512: maximum row length in coefficients. Each bank holds MaximumSideSize/2 pairs. Address width is $clog2(MaximumSideSize/2).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- s_ready_o  out  1  input ready.
- s_valid_i  in  1  input pair valid.
- s_sof_i  in  1  first pair of frame, valid with first beat of a row.
- s_eol_i  in  1  last pair of row.
- s_data_i  in  2*DataWidth  {high, low} coefficient pair.
- m_ready_i  in  1  output ready.
- m_valid_o  out  1  output coefficient valid.
- m_sof_o  out  1  first L coefficient of a frame's first row.
- m_eol_o  out  1  last H coefficient of a row.
- m_band_o  out  1  0 = L coefficient, 1 = H coefficient.
- m_data_o  out  DataWidth  coefficient.
- overflow_o  out  1  sticky: a row exceeded MaximumSideSize/2 pairs.

Behaviour:
- Storage: two banks, each MaximumSideSize/2 x 2*DataWidth, synchronous read with 1-cycle latency. Memory contents are not reset.
- Per-bank state:
  - full flag.
  - length N (pairs, 1..MaximumSideSize/2).
  - sof flag, captured from s_sof_i on the row's first accepted beat.
- Write side:
  - wr_bank and wr_ptr. s_ready_o = !full[wr_bank].
  - On accept, store the pair at wr_ptr and increment.
  - On accepted s_eol_i: full[wr_bank] <= 1, len <= wr_ptr+1, wr_ptr <= 0, wr_bank toggles.
  - Overflow: if wr_ptr == MaximumSideSize/2-1 and no eol, further beats are accepted but not written (pointer saturates), and overflow_o sets. The row closes normally at eol with N = MaximumSideSize/2.
- Read FSM:
  - IDLE: when full[rd_bank], go to READ_L and issue read addr 0.
  - READ_L: emit low halves of addr 0..N-1 with m_band_o=0. After the last L, go to READ_H.
  - READ_H: emit high halves of addr 0..N-1 with m_band_o=1. On the last H: m_eol_o=1, full[rd_bank] <= 0, rd_bank toggles, return to IDLE. If the other bank is already full, go directly to READ_L with no bubble.
- Output pipeline: 2-entry skid/prefetch after the RAM read.
  - Sustains 1 beat/cycle while m_ready_i=1.
  - Holds m_data_o, m_band_o, m_sof_o and m_eol_o stable while m_valid_o & !m_ready_i.
  - m_valid_o never drops without a handshake.
- Output flags: m_sof_o = bank sof flag on the row's first L beat only, else 0. m_eol_o appears only on the last H beat.
- Latency: eol accepted at cycle T with read side IDLE gives first m_valid_o at T+2 with m_data_o = L[0].
- Throughput: 2N output beats per N input beats. Input stalls only when both banks are full.
- Simultaneous events: a bank freed by the read side in the same cycle the write side finishes the other bank must be handled, so that neither the free nor the fill is lost. The write side may start the freed bank on the next cycle.
- Reset, including mid-row: async clear of full flags, wr/rd pointers, banks to 0, FSM to IDLE, skid entries, overflow_o.
  - Reset values: m_valid_o=0, m_sof_o=0, m_eol_o=0, m_band_o=0, m_data_o=0, s_ready_o=1.
  - A partially written or partially read row is discarded.

Test Plan:
- Row of 4 pairs {H0,L0}..{H3,L3} with values Lk=k+1, Hk=-(k+1), m_ready_i=1 → output 1,2,3,4,-1,-2,-3,-4. band=0,0,0,0,1,1,1,1. sof on first beat (s_sof_i set). eol on 8th beat. First valid 2 cycles after eol accept.
- Three back-to-back rows of 8 pairs with m_ready_i=0 held → s_ready_o drops after the 16th pair. Releasing ready drains 16 coefficients of row 0 then row 1 with no bubble between rows. Row 2 is then accepted.
- Random m_ready_i (50%) over 16 rows of 256 pairs → every coefficient in order. Outputs stable during stall. No loss or duplication. sof only on row 0.
- Row of 300 pairs with MaximumSideSize=512 → overflow_o=1 after pair 256. Output has 256 L + 256 H. eol on last H.
- Assert rst_i mid-row (pair 3 of 8 written) and mid-readout (during READ_H) → all outputs at reset values immediately. A fresh row afterwards is emitted correctly.
- Row length 1 pair {7,5} → output 5 (band 0, sof), 7 (band 1, eol).

Source files
------------

// File: rtl/row_subband_reorder.sv
// Row subband reorder: captures {high, low} coefficient pairs into ping-pong banks and
// replays each row as all L coefficients followed by all H coefficients.
module row_subband_reorder #(
    parameter int unsigned DataWidth       = 16,
    parameter int unsigned MaximumSideSize = 512
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   s_ready_o,
    input  logic                   s_valid_i,
    input  logic                   s_sof_i,
    input  logic                   s_eol_i,
    input  logic [2*DataWidth-1:0] s_data_i,
    input  logic                   m_ready_i,
    output logic                   m_valid_o,
    output logic                   m_sof_o,
    output logic                   m_eol_o,
    output logic                   m_band_o,
    output logic [DataWidth-1:0]   m_data_o,
    output logic                   overflow_o
);

    localparam int unsigned Depth      = MaximumSideSize / 2;
    localparam int unsigned AddrWidth  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned EntryWidth = DataWidth + 3;
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

    typedef enum logic [1:0] {StIdle, StReadL, StReadH} rd_state_e;

    // Write side and per-bank bookkeeping
    logic                 wr_bank_q;
    logic [AddrWidth-1:0] wr_ptr_q;
    logic                 wr_sat_q;
    logic [1:0]           full_q, full_d;
    logic [1:0]           sof_q;
    logic [AddrWidth-1:0] last_q [2];
    logic                 overflow_q;

    // Read side
    rd_state_e            rd_state_q;
    logic                 rd_bank_q;
    logic [AddrWidth-1:0] rd_addr_q;
    logic                 rd_can, rd_band, rd_last, rd_sof, rd_eol, rd_issue, rd_free;
    logic [AddrWidth-1:0] rd_addr;

    // RAM output stage and skid buffer
    logic [2*DataWidth-1:0] mem [2][Depth];
    logic [2*DataWidth-1:0] rdata_q;
    logic                   rvalid_q, rsof_q, reol_q, rband_q;
    logic [EntryWidth-1:0]  ram_entry, head, out_entry;
    logic [EntryWidth-1:0]  fifo_q [2];
    logic [EntryWidth-1:0]  fifo_d [2];
    logic [1:0]             cnt_q, cnt_d, used;
    logic                   pop, push, issue_ok;

    logic wr_accept, wr_en, wr_close;

    assign s_ready_o  = !full_q[wr_bank_q];
    assign overflow_o = overflow_q;
    assign wr_accept  = s_valid_i && s_ready_o;
    // Once saturated the last slot already holds the final kept pair; later beats are dropped.
    assign wr_en      = wr_accept && !wr_sat_q;
    assign wr_close   = wr_accept && s_eol_i;

    always_comb begin
        full_d = full_q;
        if (rd_free) full_d[rd_bank_q] = 1'b0;
        if (wr_close) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_bank_q  <= 1'b0;
            wr_ptr_q   <= '0;
            wr_sat_q   <= 1'b0;
            full_q     <= '0;
            sof_q      <= '0;
            last_q[0]  <= '0;
            last_q[1]  <= '0;
            overflow_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (wr_accept) begin
                if (wr_ptr_q == '0 && !wr_sat_q) sof_q[wr_bank_q] <= s_sof_i;
                if (wr_sat_q) overflow_q <= 1'b1;
                if (s_eol_i) begin
                    last_q[wr_bank_q] <= wr_ptr_q;
                    wr_ptr_q          <= '0;
                    wr_sat_q          <= 1'b0;
                    wr_bank_q         <= !wr_bank_q;
                end else if (wr_ptr_q == LastAddr) begin
                    wr_sat_q <= 1'b1;
                end else begin
                    wr_ptr_q <= wr_ptr_q + AddrWidth'(1);
                end
            end
        end
    end

    // Idle issues address 0 directly so a freshly closed row costs no extra cycle.
    always_comb begin
        rd_can  = 1'b0;
        rd_band = 1'b0;
        rd_addr = rd_addr_q;
        unique case (rd_state_q)
            StIdle: begin
                rd_can  = full_q[rd_bank_q];
                rd_addr = '0;
            end
            StReadL: rd_can = 1'b1;
            StReadH: begin
                rd_can  = 1'b1;
                rd_band = 1'b1;
            end
            default: ;
        endcase
    end

    assign used     = cnt_q + {1'b0, rvalid_q};
    assign issue_ok = (used < 2'd2) || pop;
    assign rd_issue = rd_can && issue_ok;
    assign rd_last  = (rd_addr == last_q[rd_bank_q]);
    assign rd_sof   = sof_q[rd_bank_q] && !rd_band && (rd_addr == '0);
    assign rd_eol   = rd_band && rd_last;
    assign rd_free  = rd_issue && rd_eol;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state_q <= StIdle;
            rd_bank_q  <= 1'b0;
            rd_addr_q  <= '0;
        end else if (rd_issue) begin
            if (!rd_last) begin
                rd_addr_q  <= rd_addr + AddrWidth'(1);
                rd_state_q <= rd_band ? StReadH : StReadL;
            end else if (!rd_band) begin
                rd_addr_q  <= '0;
                rd_state_q <= StReadH;
            end else begin
                rd_addr_q  <= '0;
                rd_bank_q  <= !rd_bank_q;
                rd_state_q <= full_q[!rd_bank_q] ? StReadL : StIdle;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_bank_q][wr_ptr_q] <= s_data_i;
        if (rd_issue) rdata_q <= mem[rd_bank_q][rd_addr];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rsof_q   <= 1'b0;
            reol_q   <= 1'b0;
            rband_q  <= 1'b0;
        end else begin
            rvalid_q <= rd_issue;
            if (rd_issue) begin
                rsof_q  <= rd_sof;
                reol_q  <= rd_eol;
                rband_q <= rd_band;
            end
        end
    end

    assign ram_entry = {rsof_q, reol_q, rband_q,
                        rband_q ? rdata_q[2*DataWidth-1:DataWidth] : rdata_q[DataWidth-1:0]};

    // With the skid empty, fresh RAM data is presented directly; otherwise the skid head.
    assign head      = (cnt_q != 2'd0) ? fifo_q[0] : ram_entry;
    assign m_valid_o = (cnt_q != 2'd0) || rvalid_q;
    assign out_entry = m_valid_o ? head : '0;
    assign {m_sof_o, m_eol_o, m_band_o, m_data_o} = out_entry;
    assign pop       = m_valid_o && m_ready_i;
    assign push      = rvalid_q && !((cnt_q == 2'd0) && pop);

    always_comb begin
        fifo_d = fifo_q;
        cnt_d  = cnt_q;
        if (pop && cnt_q != 2'd0) begin
            fifo_d[0] = fifo_q[1];
            cnt_d     = cnt_q - 2'd1;
        end
        if (push) begin
            fifo_d[cnt_d[0]] = ram_entry;
            cnt_d            = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            cnt_q     <= '0;
        end else begin
            fifo_q <= fifo_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_row_subband_reorder.sv
// Randomized bench for row_subband_reorder: a queue model lists each row's L coefficients
// then its H coefficients, truncated to MaximumSideSize/2 pairs.
module tb_row_subband_reorder;

    localparam int DW   = 16;
    localparam int MSS  = 512;
    localparam int HALF = MSS / 2;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic            s_ready_o, s_valid_i, s_sof_i, s_eol_i;
    logic [2*DW-1:0] s_data_i;
    logic            m_ready_i, m_valid_o, m_sof_o, m_eol_o, m_band_o;
    logic [DW-1:0]   m_data_o;
    logic            overflow_o;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int stall_viol = 0;

    logic [2*DW-1:0] in_data[$];
    bit              in_sof[$];
    bit              in_eol[$];
    logic [DW+2:0]   exp_q[$];
    logic [DW+2:0]   obs_q[$];
    int              obs_cyc[$];

    row_subband_reorder #(
        .DataWidth      (DW),
        .MaximumSideSize(MSS)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .s_ready_o (s_ready_o),
        .s_valid_i (s_valid_i),
        .s_sof_i   (s_sof_i),
        .s_eol_i   (s_eol_i),
        .s_data_i  (s_data_i),
        .m_ready_i (m_ready_i),
        .m_valid_o (m_valid_o),
        .m_sof_o   (m_sof_o),
        .m_eol_o   (m_eol_o),
        .m_band_o  (m_band_o),
        .m_data_o  (m_data_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic clear_q();
        in_data.delete();
        in_sof.delete();
        in_eol.delete();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    // mode 0: random, 1: Lk=k+1 / Hk=-(k+1), 2: Lk=5+k / Hk=7+k
    task automatic gen_row(input int n, input bit sof, input int mode);
        logic [DW-1:0] lo[$];
        logic [DW-1:0] hi[$];
        logic [DW-1:0] l, h;
        int kept;
        for (int k = 0; k < n; k++) begin
            if (mode == 1) begin
                l = DW'(k + 1);
                h = DW'(-(k + 1));
            end else if (mode == 2) begin
                l = DW'(5 + k);
                h = DW'(7 + k);
            end else begin
                l = DW'($urandom);
                h = DW'($urandom);
            end
            lo.push_back(l);
            hi.push_back(h);
            in_data.push_back({h, l});
            in_sof.push_back(sof && (k == 0));
            in_eol.push_back(k == n - 1);
        end
        kept = (n < HALF) ? n : HALF;
        for (int k = 0; k < kept; k++) exp_q.push_back({sof && (k == 0), 1'b0, 1'b0, lo[k]});
        for (int k = 0; k < kept; k++) exp_q.push_back({1'b0, k == kept - 1, 1'b1, hi[k]});
    endtask

    task automatic drive_head();
        s_valid_i = 1'b1;
        s_data_i  = in_data[0];
        s_sof_i   = in_sof[0];
        s_eol_i   = in_eol[0];
    endtask

    task automatic pop_head();
        void'(in_data.pop_front());
        void'(in_sof.pop_front());
        void'(in_eol.pop_front());
    endtask

    // Runs producer and consumer together; records handshakes and output changes during stalls.
    task automatic stream(input int valid_pct, input int ready_pct, input int max_out,
                          input int max_cycles);
        int n = 0;
        bit prev_stall = 1'b0;
        logic [DW+3:0] prev_vec = '0;
        logic [DW+3:0] cur_vec;
        while (!(in_data.size() == 0 && obs_q.size() >= max_out) && n < max_cycles) begin
            if (in_data.size() > 0 && $urandom_range(99) < valid_pct) drive_head();
            else s_valid_i = 1'b0;
            m_ready_i = ($urandom_range(99) < ready_pct);
            cur_vec = {m_valid_o, m_sof_o, m_eol_o, m_band_o, m_data_o};
            if (prev_stall && cur_vec !== prev_vec) stall_viol++;
            if (s_valid_i && s_ready_o) pop_head();
            if (m_valid_o && m_ready_i) begin
                obs_q.push_back(cur_vec[DW+2:0]);
                obs_cyc.push_back(cyc);
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_vec   = cur_vec;
            @(posedge clk_i);
            #1;
            n++;
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({m_valid_o, m_sof_o, m_eol_o, m_band_o, m_data_o, s_ready_o, overflow_o} !== {4'b0, 16'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values got v%b s%b e%b b%b d%h r%b o%b want zeros with ready=1",
                     m_valid_o, m_sof_o, m_eol_o, m_band_o, m_data_o, s_ready_o, overflow_o);
        end
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        n_cmp++;
        if ({m_valid_o, s_ready_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_release got valid=%b ready=%b want valid=0 ready=1", m_valid_o, s_ready_o);
        end
    endtask

    task automatic test_basic_row();
        clear_q();
        gen_row(4, 1'b1, 1);
        m_ready_i = 1'b1;
        for (int t = 0; t < 20 && in_data.size() > 0; t++) begin
            drive_head();
            if (s_ready_o) pop_head();
            @(posedge clk_i);
            #1;
        end
        s_valid_i = 1'b0;
        n_cmp++;
        if (m_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency_t1 got valid=%b want 0", m_valid_o);
        end
        @(posedge clk_i);
        #1;
        n_cmp++;
        if ({m_valid_o, m_sof_o, m_band_o, m_data_o} !== {1'b1, 1'b1, 1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL basic_latency_t2 got v%b s%b b%b d%h want v1 s1 b0 d0001",
                     m_valid_o, m_sof_o, m_band_o, m_data_o);
        end
        stream(100, 100, 8, 100);
        n_cmp++;
        if (obs_q.size() !== 8) begin
            n_fail++;
            $display("FAIL basic_count got %0d want 8", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_beat[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_single_pair();
        clear_q();
        gen_row(1, 1'b1, 2);
        stream(100, 100, 2, 50);
        n_cmp++;
        if (obs_q.size() !== 2) begin
            n_fail++;
            $display("FAIL single_count got %0d want 2", obs_q.size());
        end else begin
            n_cmp += 2;
            if (obs_q[0] !== {1'b1, 1'b0, 1'b0, 16'd5}) begin
                n_fail++;
                $display("FAIL single_l got %h want %h", obs_q[0], {1'b1, 1'b0, 1'b0, 16'd5});
            end
            if (obs_q[1] !== {1'b0, 1'b1, 1'b1, 16'd7}) begin
                n_fail++;
                $display("FAIL single_h got %h want %h", obs_q[1], {1'b0, 1'b1, 1'b1, 16'd7});
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        bit seen = 1'b0;
        logic ready_after = 1'b1;
        int bubbles = 0;
        clear_q();
        for (int r = 0; r < 3; r++) gen_row(8, r == 0, 0);
        m_ready_i = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (in_data.size() > 0 && s_ready_o) begin
                drive_head();
                pop_head();
                acc++;
            end else begin
                s_valid_i = 1'b0;
            end
            @(posedge clk_i);
            #1;
            if (acc == 16 && !seen) begin
                ready_after = s_ready_o;
                seen = 1'b1;
            end
        end
        s_valid_i = 1'b0;
        n_cmp += 3;
        if (acc !== 16) begin
            n_fail++;
            $display("FAIL b2b_accepted got %0d want 16", acc);
        end
        if (ready_after !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_drop got %b want 0", ready_after);
        end
        if ({m_valid_o, m_sof_o, m_eol_o, m_band_o, m_data_o} !== {1'b1, exp_q[0]}) begin
            n_fail++;
            $display("FAIL b2b_stalled_head got %b_%h want %b_%h", m_valid_o,
                     {m_sof_o, m_eol_o, m_band_o, m_data_o}, 1'b1, exp_q[0]);
        end
        stream(100, 100, 48, 300);
        n_cmp++;
        if (obs_q.size() !== 48) begin
            n_fail++;
            $display("FAIL b2b_count got %0d want 48", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_beat[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < 32 && i < obs_cyc.size(); i++)
            if (obs_cyc[i] - obs_cyc[i-1] != 1) bubbles++;
        n_cmp++;
        if (bubbles !== 0 || obs_cyc.size() < 32) begin
            n_fail++;
            $display("FAIL b2b_bubbles got %0d gaps over %0d beats want 0 gaps over 32", bubbles,
                     obs_cyc.size());
        end
    endtask

    task automatic test_random_rows();
        int sofs = 0;
        clear_q();
        stall_viol = 0;
        for (int r = 0; r < 16; r++) gen_row(HALF, r == 0, 0);
        stream(80, 50, 16 * MSS, 40000);
        n_cmp++;
        if (obs_q.size() !== 16 * MSS) begin
            n_fail++;
            $display("FAIL rand_count got %0d want %0d", obs_q.size(), 16 * MSS);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_beat[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][DW+2]) sofs++;
        end
        n_cmp += 2;
        if (stall_viol !== 0) begin
            n_fail++;
            $display("FAIL rand_stall_stable got %0d changes want 0", stall_viol);
        end
        if (sofs !== 1) begin
            n_fail++;
            $display("FAIL rand_sof_count got %0d want 1", sofs);
        end
    endtask

    task automatic test_overflow();
        int acc = 0;
        clear_q();
        gen_row(300, 1'b0, 0);
        m_ready_i = 1'b0;
        for (int t = 0; t < 300 && acc < HALF; t++) begin
            drive_head();
            if (s_ready_o) begin
                pop_head();
                acc++;
            end
            @(posedge clk_i);
            #1;
        end
        s_valid_i = 1'b0;
        n_cmp++;
        if (overflow_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_at_256 got %b want 0", overflow_o);
        end
        stream(100, 100, MSS, 2000);
        n_cmp += 2;
        if (overflow_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky got %b want 1", overflow_o);
        end
        if (obs_q.size() !== MSS) begin
            n_fail++;
            $display("FAIL ovf_count got %0d want %0d", obs_q.size(), MSS);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ovf_beat[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        clear_q();
        gen_row(8, 1'b1, 0);
        for (int t = 0; t < 20 && acc < 3; t++) begin
            drive_head();
            if (s_ready_o) begin
                pop_head();
                acc++;
            end
            @(posedge clk_i);
            #1;
        end
        s_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({m_valid_o, m_sof_o, m_eol_o, m_band_o, m_data_o, s_ready_o, overflow_o} !== {4'b0, 16'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_midrow got v%b d%h r%b o%b want v0 d0000 r1 o0",
                     m_valid_o, m_data_o, s_ready_o, overflow_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        clear_q();
        gen_row(8, 1'b1, 0);
        stream(100, 100, 10, 100);
        n_cmp++;
        if ({m_valid_o, m_band_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_readh_state got valid=%b band=%b want 1 1", m_valid_o, m_band_o);
        end
        #2 rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({m_valid_o, m_sof_o, m_eol_o, m_band_o, m_data_o, s_ready_o} !== {4'b0, 16'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_midread got v%b s%b e%b b%b d%h r%b want zeros with ready=1",
                     m_valid_o, m_sof_o, m_eol_o, m_band_o, m_data_o, s_ready_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        clear_q();
        gen_row(5, 1'b1, 0);
        stream(100, 70, 10, 200);
        n_cmp++;
        if (obs_q.size() !== 10) begin
            n_fail++;
            $display("FAIL rst_fresh_count got %0d want 10", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rst_fresh_beat[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        s_valid_i = 1'b0;
        s_sof_i   = 1'b0;
        s_eol_i   = 1'b0;
        s_data_i  = '0;
        m_ready_i = 1'b0;
        test_reset();
        test_basic_row();
        test_single_pair();
        test_back_to_back();
        test_random_rows();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
